// File: rtl/alu_result_buf.sv
// Result buffer behind the 16-bit adder: captures C plus Z/N/V/CY flags into a small
// FIFO with valid/ready toward write-back, and keeps a sticky overflow bit.
module alu_result_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_c,
    input  logic             in_vout,
    input  logic             in_cout,
    input  logic             in_coe,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    output logic             out_cy,
    output logic             sticky_v,
    input  logic             clr_sticky,
    output logic [CNTW-1:0]  count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] c;
        logic             z;
        logic             n;
        logic             v;
        logic             cy;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CNTW-1:0] r_count;
    logic            r_sticky;
    logic            r_cy_hold;

    logic            w_push;
    logic            w_pop;
    logic            w_cy;
    entry_t          w_new;
    entry_t          w_head;

    // in_ready depends only on registered count, so a pop never frees a slot same-cycle
    assign in_ready  = (r_count < CNTW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // in_coe gates in_cout so an undriven carry never reaches storage
    assign w_cy      = in_coe ? r_cy_hold : in_cout;

    always_comb begin
        w_new    = '0;
        w_new.c  = in_c;
        w_new.z  = (in_c == '0);
        w_new.n  = in_c[WIDTH-1];
        w_new.v  = in_vout;
        w_new.cy = w_cy;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_sticky  <= 1'b0;
            r_cy_hold <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == PW'(DEPTH-1)) ? '0 : r_wr + 1'b1;
                if (!in_coe) r_cy_hold <= in_cout;
            end
            if (w_pop)
                r_rd <= (r_rd == PW'(DEPTH-1)) ? '0 : r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && in_vout) r_sticky <= 1'b1;
            else if (clr_sticky)   r_sticky <= 1'b0;
        end
    end

    // Stale storage stays invisible: every head field is zero unless out_valid
    always_comb begin
        w_head = '0;
        if (out_valid) w_head = r_mem[r_rd];
    end

    assign out_c    = w_head.c;
    assign out_z    = w_head.z;
    assign out_n    = w_head.n;
    assign out_v    = w_head.v;
    assign out_cy   = w_head.cy;
    assign sticky_v = r_sticky;
    assign count    = r_count;

endmodule

// File: tb/tb_alu_result_buf.sv
// Directed bench for alu_result_buf with a queue scoreboard of expected head entries.
module tb_alu_result_buf;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;
    localparam int CNTW  = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_c;
    logic             in_vout;
    logic             in_cout;
    logic             in_coe;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_c;
    logic             out_z;
    logic             out_n;
    logic             out_v;
    logic             out_cy;
    logic             sticky_v;
    logic             clr_sticky;
    logic [CNTW-1:0]  count;

    alu_result_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c),
        .in_vout(in_vout), .in_cout(in_cout), .in_coe(in_coe),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .out_z(out_z), .out_n(out_n), .out_v(out_v), .out_cy(out_cy),
        .sticky_v(sticky_v), .clr_sticky(clr_sticky), .count(count)
    );

    typedef struct {
        logic [WIDTH-1:0] c;
        logic             z;
        logic             n;
        logic             v;
        logic             cy;
    } exp_t;

    exp_t q[$];
    logic m_cy;
    logic m_sticky;
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Mid-cycle check of all outputs against the model, then advance the model by one edge
    task automatic tick();
        bit   push, pop;
        exp_t e;
        @(negedge clk);
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("sticky_v", 32'(sticky_v), 32'(m_sticky));
        chk("out_x", 32'($isunknown({out_c, out_z, out_n, out_v, out_cy, count, in_ready, out_valid})), 32'(0));
        if (q.size() != 0) begin
            chk("out_c", 32'(out_c), 32'(q[0].c));
            chk("out_z", 32'(out_z), 32'(q[0].z));
            chk("out_n", 32'(out_n), 32'(q[0].n));
            chk("out_v", 32'(out_v), 32'(q[0].v));
            chk("out_cy", 32'(out_cy), 32'(q[0].cy));
        end else begin
            chk("idle_zero", 32'({out_c, out_z, out_n, out_v, out_cy}), 32'(0));
        end
        push = (in_valid === 1'b1) && (q.size() < DEPTH);
        pop  = (out_ready === 1'b1) && (q.size() != 0);
        if (pop) void'(q.pop_front());
        if (push) begin
            e.c  = in_c;
            e.z  = (in_c == 16'h0000);
            e.n  = in_c[15];
            e.v  = in_vout;
            e.cy = in_coe ? m_cy : in_cout;
            q.push_back(e);
            if (!in_coe) m_cy = in_cout;
        end
        if (push && in_vout) m_sticky = 1'b1;
        else if (clr_sticky) m_sticky = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] c, input logic vo,
                         input logic co, input logic coe);
        in_valid = v;
        in_c     = c;
        in_vout  = vo;
        in_cout  = co;
        in_coe   = coe;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_c = '0; in_vout = 1'b0; in_cout = 1'b0;
        in_coe = 1'b1; out_ready = 1'b0; clr_sticky = 1'b0;
        m_cy = 1'b0; m_sticky = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_sticky", 32'(sticky_v), 32'(0));
        chk("rst_outs", 32'({out_c, out_z, out_n, out_v, out_cy}), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: zero result with carry, immediate consume
        out_ready = 1'b1;
        drive(1, 16'h0000, 0, 1, 0); tick();
        drive(0, 16'h0000, 0, 0, 1);
        chk("t1_head_z", 32'(out_z), 32'(1));
        chk("t1_head_cy", 32'(out_cy), 32'(1));
        tick();
        tick();

        // 2: fill to full, third producer word waits until a pop frees space
        out_ready = 1'b0;
        drive(1, 16'h8000, 1, 0, 1); tick();
        drive(1, 16'h0001, 0, 0, 1); tick();
        drive(1, 16'h0002, 0, 0, 1);
        chk("t2_full_in_ready", 32'(in_ready), 32'(0));
        chk("t2_head_n", 32'(out_n), 32'(1));
        tick();
        tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        drive(0, 16'h0000, 0, 0, 1);
        chk("t2_third_accepted", 32'(count), 32'(2));
        out_ready = 1'b1; tick(); tick(); tick();

        // 3: held carry reused while in_cout is undriven
        out_ready = 1'b0;
        drive(1, 16'h1234, 0, 1, 0); tick();
        drive(1, 16'h4321, 0, 1'bx, 1); tick();
        drive(0, 16'h0000, 0, 0, 1);
        out_ready = 1'b1; tick();
        chk("t3_second_cy", 32'(out_cy), 32'(1));
        tick(); tick();

        // 4: streaming push+pop at count=1 across pointer wraps
        out_ready = 1'b1;
        drive(1, 16'd1, 0, 0, 0); tick();
        for (int v = 2; v <= 9; v++) begin
            drive(1, 16'(v), 0, v[0], 0);
            tick();
        end
        drive(0, 16'h0000, 0, 0, 1);
        tick(); tick();

        // 5: set beats clear on the same edge, clear alone then takes effect
        clr_sticky = 1'b1;
        drive(1, 16'h7fff, 1, 0, 0); tick();
        drive(0, 16'h0000, 0, 0, 1);
        clr_sticky = 1'b0;
        tick();
        chk("t5_set_wins", 32'(sticky_v), 32'(1));
        clr_sticky = 1'b1; tick();
        clr_sticky = 1'b0; tick();
        chk("t5_cleared", 32'(sticky_v), 32'(0));

        // 6: asynchronous reset while two entries are held
        out_ready = 1'b0;
        drive(1, 16'hbeef, 1, 1, 0); tick();
        drive(1, 16'hcafe, 0, 0, 0); tick();
        drive(0, 16'h0000, 0, 0, 1);
        chk("t6_pre_count", 32'(count), 32'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'(0));
        chk("t6_count", 32'(count), 32'(0));
        chk("t6_in_ready", 32'(in_ready), 32'(1));
        chk("t6_sticky", 32'(sticky_v), 32'(0));
        chk("t6_outs", 32'({out_c, out_z, out_n, out_v, out_cy}), 32'(0));
        q.delete();
        m_cy = 1'b0;
        m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
